// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus arbiter: round-robin grant, one-cycle snoop broadcast, and a line fill
// from the lowest-indexed hitting peer, or from L2 when no peer hits.
module snoop_bus_arbiter #(
  parameter int NUM_CORES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      req_core,
  input  logic [2*NUM_CORES-1:0]    bus_operation_out,
  input  logic [32*NUM_CORES-1:0]   bus_address_out,
  input  logic [32*NUM_CORES-1:0]   bus_data_out,
  input  logic [NUM_CORES-1:0]      cache_hit_out,
  output logic [NUM_CORES-1:0]      grant,
  output logic [2*NUM_CORES-1:0]    bus_operation_in,
  output logic [32*NUM_CORES-1:0]   bus_address_in,
  output logic [32*NUM_CORES-1:0]   bus_data_in,
  output logic [2*NUM_CORES-1:0]    cache_hit_in,
  output logic                      l2_rd_req,
  output logic [31:0]               l2_addr,
  input  logic                      l2_rd_valid,
  input  logic [31:0]               l2_rd_data
);

  localparam int OW = $clog2(NUM_CORES);
  localparam logic [1:0] OP_UPGR = 2'b01;
  localparam logic [1:0] OP_NONE = 2'b11;
  localparam logic [NUM_CORES-1:0] ONE = NUM_CORES'(1);

  typedef enum logic [2:0] {IDLE, GRANTED, SNOOP, L2WAIT, RESP, HOLD} state_t;

  state_t        state;
  logic [OW-1:0] last_owner;  // doubles as the current owner once granted
  logic [1:0]    op_q;
  logic [31:0]   addr_q;

  logic          pick_valid;
  logic [OW-1:0] pick_idx;
  logic [NUM_CORES-1:0] peer_hits;
  logic [31:0]   peer_data;
  logic [1:0]    owner_op;
  logic [31:0]   owner_addr;
  logic [31:0]   owner_data;
  int            cand;

  assign owner_op   = bus_operation_out[2*last_owner +: 2];
  assign owner_addr = bus_address_out[32*last_owner +: 32];
  assign owner_data = bus_data_out[32*last_owner +: 32];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand = (int'(last_owner) + i) % NUM_CORES;
      if (!pick_valid && req_core[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[OW-1:0];
      end
    end
  end

  // The owner never snoops itself; scanning downward leaves the lowest-indexed hit.
  always_comb begin
    peer_hits = cache_hit_out & ~grant;
    peer_data = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (peer_hits[i]) peer_data = bus_data_out[32*i +: 32];
    end
  end

  // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      last_owner       <= OW'(NUM_CORES - 1);
      op_q             <= OP_NONE;
      addr_q           <= '0;
      grant            <= '0;
      bus_operation_in <= '1;
      bus_address_in   <= '0;
      bus_data_in      <= '0;
      cache_hit_in     <= '0;
      l2_rd_req        <= 1'b0;
      l2_addr          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant      <= ONE << pick_idx;
            last_owner <= pick_idx;
            state      <= GRANTED;
          end
        end
        GRANTED: begin
          if (owner_op != OP_NONE) begin
            op_q   <= owner_op;
            addr_q <= owner_addr;
            for (int i = 0; i < NUM_CORES; i++) begin
              if (i == int'(last_owner)) begin
                bus_operation_in[2*i +: 2] <= OP_NONE;
                bus_address_in[32*i +: 32] <= '0;
                bus_data_in[32*i +: 32]    <= '0;
              end else begin
                bus_operation_in[2*i +: 2] <= owner_op;
                bus_address_in[32*i +: 32] <= owner_addr;
                bus_data_in[32*i +: 32]    <= owner_data;
              end
            end
            state <= SNOOP;
          end else if (!req_core[last_owner]) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        SNOOP: begin
          bus_operation_in <= '1;
          bus_address_in   <= '0;
          bus_data_in      <= '0;
          if (op_q == OP_UPGR || peer_hits != '0) begin
            cache_hit_in[2*last_owner +: 2] <= {1'b1, |peer_hits};
            bus_data_in[32*last_owner +: 32] <= (op_q == OP_UPGR) ? 32'h0 : peer_data;
            state <= RESP;
          end else begin
            l2_rd_req <= 1'b1;
            l2_addr   <= addr_q;
            state     <= L2WAIT;
          end
        end
        L2WAIT: begin
          if (l2_rd_valid) begin
            l2_rd_req <= 1'b0;
            l2_addr   <= '0;
            cache_hit_in[2*last_owner +: 2]  <= 2'b10;
            bus_data_in[32*last_owner +: 32] <= l2_rd_data;
            state <= RESP;
          end
        end
        RESP: begin
          cache_hit_in <= '0;
          bus_data_in  <= '0;
          state        <= HOLD;
        end
        HOLD: begin
          if (!req_core[last_owner]) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter with two cores: a cycle-by-cycle vector table for
// the L2 fill, then hand sequences for round-robin, peer fill, upgrade, reset and early release.
module tb_snoop_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_core;
  logic [3:0]  bus_operation_out;
  logic [63:0] bus_address_out;
  logic [63:0] bus_data_out;
  logic [1:0]  cache_hit_out;
  logic [1:0]  grant;
  logic [3:0]  bus_operation_in;
  logic [63:0] bus_address_in;
  logic [63:0] bus_data_in;
  logic [3:0]  cache_hit_in;
  logic        l2_rd_req;
  logic [31:0] l2_addr;
  logic        l2_rd_valid;
  logic [31:0] l2_rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  snoop_bus_arbiter #(.NUM_CORES(2)) dut (
    .clk(clk), .reset(reset), .req_core(req_core),
    .bus_operation_out(bus_operation_out), .bus_address_out(bus_address_out),
    .bus_data_out(bus_data_out), .cache_hit_out(cache_hit_out),
    .grant(grant), .bus_operation_in(bus_operation_in), .bus_address_in(bus_address_in),
    .bus_data_in(bus_data_in), .cache_hit_in(cache_hit_in),
    .l2_rd_req(l2_rd_req), .l2_addr(l2_addr),
    .l2_rd_valid(l2_rd_valid), .l2_rd_data(l2_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [3:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  hit;
    logic        l2v;
    logic [31:0] l2d;
    logic [1:0]  e_grant;
    logic [3:0]  e_op;
    logic [63:0] e_addr;
    logic [63:0] e_data;
    logic [3:0]  e_chi;
    logic        e_l2req;
    logic [31:0] e_l2addr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_core = 2'b00;
    bus_operation_out = 4'b1111;
    bus_address_out = '0;
    bus_data_out = '0;
    cache_hit_out = 2'b00;
    l2_rd_valid = 1'b0;
    l2_rd_data = '0;
    tick;
    tick;
    reset = 1'b0;
    tick;
  endtask

  // Runs one snoop-served transaction for core c (which must already be requesting with op).
  task automatic do_txn(input int c, input logic [1:0] op, input logic [1:0] exp_chi,
                        input logic [31:0] exp_data, input string tag);
    int k;
    logic l2_seen;
    logic [1:0] eg;
    l2_seen = 1'b0;
    eg = 2'b01 << c;
    k = 0;
    while (grant == 2'b00 && k < 20) begin
      tick;
      k++;
      if (l2_rd_req) l2_seen = 1'b1;
    end
    check($sformatf("%s grant", tag), grant, eg);
    tick;
    check($sformatf("%s snoop peer op", tag), bus_operation_in[2*(1-c) +: 2], op);
    check($sformatf("%s snoop owner op", tag), bus_operation_in[2*c +: 2], 2'b11);
    tick;
    if (l2_rd_req) l2_seen = 1'b1;
    check($sformatf("%s resp chi", tag), cache_hit_in[2*c +: 2], exp_chi);
    check($sformatf("%s resp data", tag), bus_data_in[32*c +: 32], exp_data);
    check($sformatf("%s resp peer op", tag), bus_operation_in[2*(1-c) +: 2], 2'b11);
    req_core[c] = 1'b0;
    k = 0;
    while (grant != 2'b00 && k < 20) begin
      tick;
      k++;
      if (l2_rd_req) l2_seen = 1'b1;
    end
    check($sformatf("%s release", tag), grant, 2'b00);
    check($sformatf("%s no l2", tag), l2_seen, 1'b0);
  endtask

  initial begin
    int k;
    vecs[0] = '{2'b01, 4'b1100, 64'h40, 64'h11, 2'b00, 1'b0, 32'h0,
                2'b01, 4'b1111, 64'h0, 64'h0, 4'h0, 1'b0, 32'h0};
    vecs[1] = '{2'b01, 4'b1100, 64'h40, 64'h11, 2'b00, 1'b0, 32'h0,
                2'b01, 4'b0011, 64'h0000_0040_0000_0000, 64'h0000_0011_0000_0000, 4'h0, 1'b0, 32'h0};
    vecs[2] = '{2'b01, 4'b1100, 64'h40, 64'h11, 2'b00, 1'b0, 32'h0,
                2'b01, 4'b1111, 64'h0, 64'h0, 4'h0, 1'b1, 32'h40};
    vecs[3] = vecs[2];
    vecs[4] = vecs[2];
    vecs[5] = '{2'b01, 4'b1100, 64'h40, 64'h11, 2'b00, 1'b1, 32'hDEADBEEF,
                2'b01, 4'b1111, 64'h0, 64'h0000_0000_DEAD_BEEF, 4'b0010, 1'b0, 32'h0};
    vecs[6] = '{2'b01, 4'b1100, 64'h40, 64'h11, 2'b00, 1'b0, 32'h0,
                2'b01, 4'b1111, 64'h0, 64'h0, 4'h0, 1'b0, 32'h0};
    vecs[7] = '{2'b00, 4'b1111, 64'h0, 64'h0, 2'b00, 1'b0, 32'h0,
                2'b00, 4'b1111, 64'h0, 64'h0, 4'h0, 1'b0, 32'h0};
    vecs[8] = vecs[7];

    // Reset values while reset is held.
    reset = 1'b1;
    req_core = 2'b11;
    bus_operation_out = 4'b0000;
    bus_address_out = '0;
    bus_data_out = '0;
    cache_hit_out = 2'b00;
    l2_rd_valid = 1'b0;
    l2_rd_data = '0;
    tick;
    check("rst grant", grant, 2'b00);
    check("rst op", bus_operation_in, 4'b1111);
    check("rst addr", bus_address_in, 64'h0);
    check("rst data", bus_data_in, 64'h0);
    check("rst chi", cache_hit_in, 4'h0);
    check("rst l2", {l2_rd_req, l2_addr}, 33'h0);

    // BusRd with no peer hit, filled from L2.
    do_reset;
    for (int i = 0; i < 9; i++) begin
      req_core = vecs[i].req;
      bus_operation_out = vecs[i].op;
      bus_address_out = vecs[i].addr;
      bus_data_out = vecs[i].data;
      cache_hit_out = vecs[i].hit;
      l2_rd_valid = vecs[i].l2v;
      l2_rd_data = vecs[i].l2d;
      tick;
      check($sformatf("v%0d grant", i), grant, vecs[i].e_grant);
      check($sformatf("v%0d op", i), bus_operation_in, vecs[i].e_op);
      check($sformatf("v%0d addr", i), bus_address_in, vecs[i].e_addr);
      check($sformatf("v%0d data", i), bus_data_in, vecs[i].e_data);
      check($sformatf("v%0d chi", i), cache_hit_in, vecs[i].e_chi);
      check($sformatf("v%0d l2req", i), l2_rd_req, vecs[i].e_l2req);
      check($sformatf("v%0d l2addr", i), l2_addr, vecs[i].e_l2addr);
    end

    // Round-robin: core0, core1, core0 with both always re-requesting.
    do_reset;
    req_core = 2'b11;
    bus_operation_out = 4'b0101;
    bus_address_out = {32'h300, 32'h200};
    do_txn(0, 2'b01, 2'b10, 32'h0, "rr0");
    req_core[0] = 1'b1;
    do_txn(1, 2'b01, 2'b10, 32'h0, "rr1");
    req_core[1] = 1'b1;
    do_txn(0, 2'b01, 2'b10, 32'h0, "rr2");

    // BusRdX served by a peer hit.
    do_reset;
    req_core = 2'b01;
    bus_operation_out = 4'b1110;
    bus_address_out = {32'h0, 32'h80};
    bus_data_out = {32'h12345678, 32'h0};
    cache_hit_out = 2'b10;
    do_txn(0, 2'b10, 2'b11, 32'h12345678, "rdx");

    // BusUpgr from core1 with a peer hit: data is zero.
    do_reset;
    req_core = 2'b10;
    bus_operation_out = 4'b0111;
    bus_address_out = {32'h100, 32'h0};
    bus_data_out = {32'h0, 32'hAAAA5555};
    cache_hit_out = 2'b01;
    do_txn(1, 2'b01, 2'b11, 32'h0, "upgr");

    // Asynchronous reset in the middle of L2WAIT.
    do_reset;
    req_core = 2'b01;
    bus_operation_out = 4'b1100;
    bus_address_out = {32'h0, 32'h40};
    k = 0;
    while (!l2_rd_req && k < 20) begin
      tick;
      k++;
    end
    check("mid l2 req", l2_rd_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async l2req", l2_rd_req, 1'b0);
    check("async grant", grant, 2'b00);
    check("async chi", cache_hit_in, 4'h0);
    check("async op", bus_operation_in, 4'b1111);
    req_core = 2'b00;
    bus_operation_out = 4'b1111;
    tick;
    reset = 1'b0;
    l2_rd_valid = 1'b1;
    l2_rd_data = 32'hBAD0BAD0;
    tick;
    l2_rd_valid = 1'b0;
    check("late l2 chi", cache_hit_in, 4'h0);
    check("late l2 data", bus_data_in, 64'h0);
    check("late l2 grant", grant, 2'b00);
    req_core = 2'b11;
    tick;
    check("post rst first", grant, 2'b01);

    // Owner drops its request in GRANTED without an op while core1 waits.
    req_core[0] = 1'b0;
    tick;
    check("drop grant low", grant, 2'b00);
    tick;
    check("drop next owner", grant, 2'b10);
    req_core = 2'b00;
    tick;
    tick;
    check("drop final idle", grant, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
